// File: rtl/formula_n_pkg.sv
// Shared types and width helpers for the N-argument isqrt-sum formula FSM.
package formula_n_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Sum of n values of w/2 bits each never exceeds this width.
  function automatic int sum_w(input int w, input int n);
    return w / 2 + $clog2(n + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/formula_n_pipe_aware_fsm_isqrt_result_accumulator.sv
// Counts returning isqrt results and sums them; done fires on the edge that
// takes the final result, with o_sum_next carrying the completed sum.
module isqrt_result_accumulator
  import formula_n_pkg::*;
#(
  parameter int N_ARGS = 3,
  parameter int Y_W    = 16,
  parameter int SUM_W  = 18
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_y_vld,
  input  logic [Y_W-1:0]   i_y,
  output logic             o_done,
  output logic [SUM_W-1:0] o_sum_next
);

  localparam int RC_W = $clog2(N_ARGS + 1);

  logic [RC_W-1:0]  r_cnt;
  logic [SUM_W-1:0] r_acc;
  logic             w_take;

  assign w_take     = i_en & i_y_vld;
  assign o_sum_next = r_acc + SUM_W'(i_y);
  assign o_done     = w_take && (r_cnt == RC_W'(N_ARGS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= o_sum_next;
    end
  end

endmodule

// File: rtl/formula_n_pipe_aware_fsm.sv
// Issues N_ARGS captured arguments to an external pipelined isqrt and sums the
// results; flags isqrt results that arrive while no operation is active.
module formula_n_pipe_aware_fsm
  import formula_n_pkg::*;
#(
  parameter  int N_ARGS = 3,
  parameter  int W      = 32,
  localparam int SUM_W  = sum_w(W, N_ARGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arg_vld,
  output logic                arg_rdy,
  input  logic [N_ARGS*W-1:0] arg,
  output logic                res_vld,
  output logic [SUM_W-1:0]    res,
  output logic                err_spurious,
  output logic                isqrt_x_vld,
  output logic [W-1:0]        isqrt_x,
  input  logic                isqrt_y_vld,
  input  logic [W/2-1:0]      isqrt_y
);

  localparam int CNT_W = cnt_w(N_ARGS);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_issue_cnt;
  logic [N_ARGS-1:0][W-1:0]  r_args;
  logic [SUM_W-1:0]          r_res;
  logic                      r_err;

  logic                      w_accept;
  logic                      w_acc_en;
  logic                      w_last_issue;
  logic                      w_done;
  logic [SUM_W-1:0]          w_sum_next;

  assign arg_rdy      = (r_state == IDLE) || (r_state == DONE);
  assign w_accept     = arg_vld & arg_rdy;
  assign w_acc_en     = (r_state == ISSUE) || (r_state == WAIT);
  assign w_last_issue = (r_state == ISSUE) && (r_issue_cnt == CNT_W'(N_ARGS - 1));
  assign res_vld      = (r_state == DONE);
  assign res          = r_res;
  assign err_spurious = r_err;
  assign isqrt_x_vld  = (r_state == ISSUE);

  always_comb begin
    isqrt_x = '0;
    if (r_state == ISSUE) isqrt_x = r_args[r_issue_cnt];
  end

  isqrt_result_accumulator #(
    .N_ARGS (N_ARGS),
    .Y_W    (W / 2),
    .SUM_W  (SUM_W)
  ) u_acc (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_clr      (w_accept),
    .i_en       (w_acc_en),
    .i_y_vld    (isqrt_y_vld),
    .i_y        (isqrt_y),
    .o_done     (w_done),
    .o_sum_next (w_sum_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_args      <= '0;
      r_res       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_args      <= arg;
        r_issue_cnt <= '0;
        r_state     <= ISSUE;
      end else begin
        case (r_state)
          ISSUE: begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
            // With a short isqrt latency the last result can land on the last issue.
            if (w_done)            r_state <= DONE;
            else if (w_last_issue) r_state <= WAIT;
          end
          WAIT:    if (w_done) r_state <= DONE;
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
      if (w_done) r_res <= w_sum_next;
      if (isqrt_y_vld && !w_acc_en) r_err <= 1'b1;
    end
  end

endmodule

// File: doc/formula_n_pipe_aware_fsm.md
Name: formula_n_pipe_aware_fsm

Overview:
- Parametrised successor of the 3-argument pipe-aware formula FSM.
- Computes res = sum over k of isqrt(arg[k]) for N_ARGS arguments, using one external pipelined isqrt instance.
- Sits inside formula_n_pipe_aware_fsm_top, next to that isqrt instance.
- Adds input capture, a ready/valid input handshake, a parametrised width and argument count, and detection of unexpected isqrt results.

Parameters:
- N_ARGS, 3: number of arguments per operation; must be >= 1.
- W, 32: argument width; must be even and >= 2. isqrt_y width is W/2.
- SUM_W (localparam), W/2 + $clog2(N_ARGS+1): result width; cannot overflow.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- arg_vld  in  1  argument set valid.
- arg_rdy  out  1  block can accept an argument set this cycle.
- arg  in  N_ARGS*W  packed arguments; arg[k] = arg[k*W +: W].
- res_vld  out  1  one-cycle pulse; res is valid.
- res  out  SUM_W  registered sum; held until the next result.
- err_spurious  out  1  sticky flag: an isqrt result arrived while no operation was active.
- isqrt_x_vld  out  1  request valid to isqrt.
- isqrt_x  out  W  request operand.
- isqrt_y_vld  in  1  isqrt result valid.
- isqrt_y  in  W/2  isqrt result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; issue and result counters 0.
  - res=0, res_vld=0, err_spurious=0, isqrt_x_vld=0, isqrt_x=0.
  - arg_rdy=1 after release.
- States: IDLE, ISSUE, WAIT, DONE. arg_rdy=1 in IDLE and DONE only.
- Accept:
  - At the edge with arg_vld & arg_rdy, all N_ARGS arguments are latched into an internal register.
  - Accumulator cleared; issue_cnt=0; result_cnt=0; next state ISSUE.
  - arg may change freely after acceptance.
- ISSUE:
  - isqrt_x_vld=1 and isqrt_x=arg_reg[issue_cnt] for exactly N_ARGS consecutive cycles, in order k=0..N_ARGS-1.
  - After the last issue, next state WAIT. If result_cnt completes in the same cycle, go directly to DONE.
- Accumulate:
  - In ISSUE or WAIT, each isqrt_y_vld adds zero-extended isqrt_y to the accumulator and increments result_cnt.
  - This covers the case where results return during ISSUE, when isqrt latency is shorter than N_ARGS.
- Completion:
  - On the edge where result_cnt reaches N_ARGS (counting the final isqrt_y), load res with the final sum and enter DONE.
- DONE:
  - Lasts one cycle; res_vld=1.
  - Accepting a new set in DONE goes straight to ISSUE.
  - Otherwise the next state is IDLE.
- Latency and throughput, with isqrt latency L (x_vld to y_vld):
  - Accept edge T; issues in cycles T+1..T+N_ARGS.
  - res_vld in cycle T+N_ARGS+L+1.
  - Minimum accept spacing is N_ARGS+L+1 cycles.
- arg_vld while arg_rdy=0 is ignored; no queuing.
- isqrt_y_vld in IDLE or DONE is ignored for the sum and sets err_spurious. The flag clears only on reset.
- Reset mid-operation aborts immediately. Results still in the isqrt pipe then count as spurious, so the top resets isqrt on the same rst.
- N_ARGS=1: a single issue cycle; behaviour otherwise identical.
- res holds its last value through IDLE and is not cleared at accept.

Decomposition:
- Package formula_n_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT, DONE};
  - a function for SUM_W from W and N_ARGS.
- One sub-module, isqrt_result_accumulator, is natural. It contains the result counter, the accumulator, the done strobe and the clear input.
- The FSM, argument register and issue mux stay in the top module.

Test Plan (N_ARGS=3, W=32, isqrt model latency L=4 unless stated):
- Basic: accept args 16, 25, 36 at T.
  - isqrt_x = 16, 25, 36 in cycles T+1..T+3.
  - res_vld in cycle T+8 with res=15.
- Max values: all args 0xFFFFFFFF → res=196605 (0x2FFFD). No overflow; SUM_W=18.
- Back-to-back: second set {1, 4, 9} offered and held from T+1.
  - arg_rdy stays low until T+8; the set is accepted at T+8.
  - res=6 at T+16.
- L=1 overlap: results arrive while ISSUE is still active.
  - The sum is still correct, e.g. {100, 0, 49} → 17.
  - res_vld occurs N_ARGS+2 cycles after accept.
- Spurious and reset:
  - Pulse isqrt_y_vld in IDLE → err_spurious=1, res unchanged.
  - Drive rst=0 in WAIT → all outputs return to reset values asynchronously, with no res_vld.
- N_ARGS=1, W=16: arg 0xFFFF → res=255 two cycles after L.
